sha256_msg_schedule: RTL and testbench

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_msg_schedule.sv | 95 +++++++++
 tb/tb_sha256_msg_schedule.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule: loads M[0..15], expands W[16..63] one word per cycle
module sha256_msg_schedule #(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_w_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_w,
  output logic [5:0]       o_round,
  output logic             o_done
);

  typedef enum logic {LOAD, EXPAND} state_t;

  localparam logic [5:0] LOAD_LAST_T = 6'd15;
  localparam logic [5:0] LAST_T      = 6'(ROUNDS - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] win [16];
  logic [5:0]       t;
  logic             gen_done;
  logic             slot_free;
  logic             accept;
  logic             gen;
  logic [WIDTH-1:0] w_exp;
  logic [WIDTH-1:0] w_in;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    logic [2*WIDTH-1:0] d;
    d = {x, x} >> n;
    return d[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sig0(input logic [WIDTH-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WIDTH-1:0] sig1(input logic [WIDTH-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win[0] is W[t-16], win[15] is W[t-1]
  always_comb begin
    slot_free = !o_w_valid || i_ready;
    o_ready   = (state == LOAD) && slot_free;
    accept    = i_valid && o_ready;
    gen       = (state == EXPAND) && !gen_done && slot_free;
    o_done    = o_w_valid && i_ready && (o_round == LAST_T);
    w_exp     = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    w_in      = accept ? i_word : w_exp;
    state_nx  = state;
    case (state)
      LOAD:   if (accept && (t == LOAD_LAST_T)) state_nx = EXPAND;
      EXPAND: if (gen_done && o_done)           state_nx = LOAD;
      default:                                  state_nx = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= LOAD;
      t         <= '0;
      gen_done  <= 1'b0;
      o_w_valid <= 1'b0;
      o_w       <= '0;
      o_round   <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept || gen) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15]   <= w_in;
        o_w       <= w_in;
        o_round   <= t;
        o_w_valid <= 1'b1;
        // After the last round, t parks at 0 so the next block starts clean
        if (gen && (t == LAST_T)) begin
          t        <= '0;
          gen_done <= 1'b1;
        end else begin
          t <= t + 6'd1;
        end
      end else if (o_w_valid && i_ready) begin
        o_w_valid <= 1'b0;
      end
      if ((state == EXPAND) && (state_nx == LOAD)) gen_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - scoreboard bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_word;
  logic        o_w_valid;
  logic        i_ready;
  logic [31:0] o_w;
  logic [5:0]  o_round;
  logic        o_done;

  sha256_msg_schedule #(.WIDTH(32), .ROUNDS(64)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_word   (i_word),
    .o_w_valid(o_w_valid),
    .i_ready  (i_ready),
    .o_w      (o_w),
    .o_round  (o_round),
    .o_done   (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef logic [31:0] blk_t [16];
  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  r;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got [64];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  bit          rdy_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: whole 64-word schedule from the FIPS 180-4 recurrence
  task automatic push_expected(input blk_t m);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 64; i++) begin
      e.w = w[i];
      e.r = 6'(i);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit          pv;
    logic [31:0] pw;
    logic [5:0]  pr;
    exp_t        e;
    pv = 1'b0;
    pw = '0;
    pr = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          check("stall_valid", 32'(o_w_valid), 32'd1);
          check("stall_w", o_w, pw);
          check("stall_round", 32'(o_round), 32'(pr));
        end
        pv = o_w_valid && !i_ready;
        pw = o_w;
        pr = o_round;
        if (o_w_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transfer actual=round %0d required=no transfer", o_round);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("w[%0d]", e.r), o_w, e.w);
            check($sformatf("round[%0d]", e.r), 32'(o_round), 32'(e.r));
            check($sformatf("done[%0d]", e.r), 32'(o_done), 32'(e.r == 6'd63));
            got[e.r] = o_w;
            if (o_done) done_cnt++;
          end
        end else begin
          check("done_idle", 32'(o_done), 32'd0);
        end
      end
    end
  end

  task automatic load_block(input blk_t m, input bit rand_valid);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    push_expected(m);
    while (idx < 16 && guard < 2000) begin
      @(posedge i_clk);
      #1;
      i_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_word  = i_valid ? m[idx] : $urandom;
      @(negedge i_clk);
      if (i_valid && o_ready) idx++;
      guard++;
    end
    check("load_complete", 32'(idx), 32'd16);
  endtask

  task automatic finish_block(input bit check_bubbles);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge i_clk);
      #1;
      i_valid = 1'b1;
      i_word  = $urandom;
      @(negedge i_clk);
      cyc++;
      if (o_done) seen = 1'b1;
      else check("o_ready_in_expand", 32'(o_ready), 32'd0);
    end
    check("done_seen", 32'(seen), 32'd1);
    if (check_bubbles) check("cycles_m15_to_done", 32'(cyc), 32'd49);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("ready_after_done", 32'(o_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    blk_t        abc, zero, rnd;
    logic [31:0] acc;
    int          guard;
    bit          hit;
    for (int i = 0; i < 16; i++) begin
      abc[i]  = '0;
      zero[i] = '0;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_word  = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    check("rst_o_w_valid", 32'(o_w_valid), 32'd0);
    check("rst_o_w", o_w, 32'd0);
    check("rst_o_round", 32'(o_round), 32'd0);
    check("rst_o_done", 32'(o_done), 32'd0);

    load_block(abc, 1'b0);
    finish_block(1'b1);
    check("abc_w0", got[0], 32'h61626380);
    check("abc_w15", got[15], 32'h00000018);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);

    load_block(zero, 1'b0);
    finish_block(1'b1);
    acc = '0;
    for (int i = 0; i < 64; i++) acc = acc | got[i];
    check("zero_block_or", acc, 32'd0);
    check("done_count_two_blocks", 32'(done_cnt), 32'd2);

    rdy_rand = 1'b1;
    load_block(abc, 1'b1);
    finish_block(1'b0);
    check("abc_stalled_w17", got[17], 32'h000F0000);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) rnd[i] = $urandom;
      load_block(rnd, 1'b1);
      finish_block(1'b0);
    end
    rdy_rand = 1'b0;

    load_block(abc, 1'b0);
    guard = 0;
    hit = 1'b0;
    while (!hit && guard < 200) begin
      @(posedge i_clk);
      #1;
      i_valid = 1'b1;
      i_word  = $urandom;
      @(negedge i_clk);
      guard++;
      if (o_w_valid && o_round == 6'd40) hit = 1'b1;
    end
    check("reached_round40", 32'(hit), 32'd1);
    @(posedge i_clk);
    #1;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    check("post_rst_o_w_valid", 32'(o_w_valid), 32'd0);
    check("post_rst_o_ready", 32'(o_ready), 32'd1);
    check("post_rst_o_round", 32'(o_round), 32'd0);

    load_block(abc, 1'b0);
    finish_block(1'b1);
    check("abc_after_rst_w16", got[16], 32'h61626380);
    check("abc_after_rst_w17", got[17], 32'h000F0000);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_count_total", 32'(done_cnt), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
